block_fit_check: RTL and testbench
==================================

BLOCK_FIT_CHECK -- requirements
Module: block_fit_check

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, board width in cells.
REQ-002 SHALL have parameter BOARD_H, default 20, board height in cells.
REQ-003 SHALL derive X_W=clog2(BOARD_W), Y_W=clog2(BOARD_H), A_W=clog2(BOARD_W*BOARD_H).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  high only in IDLE.
REQ-009 req_block  in  3  piece code: EMPTY=0, I=1, O=2, T=3, S=4, Z=5, J=6, L=7.
REQ-010 req_x  in  X_W  anchor column; req_y  in  Y_W  anchor row.
REQ-011 req_rot  in  2  rotation 0..3.
REQ-012 rd_en  out  1  board read strobe.
REQ-013 rd_addr  out  A_W  cell index y*BOARD_W+x.
REQ-014 rd_data  in  1  occupancy of the cell at rd_addr, valid one cycle after rd_en.
REQ-015 resp_valid  out  1  result held until accepted.
REQ-016 resp_ready  in  1  consumer accepts the result.
REQ-017 resp_fit, resp_oob, resp_hit  out  1 each  placement legal / out of bounds / overlaps an occupied cell.
REQ-018 resp_cells  out  4*A_W  four cell indices, cell 1 in the LSBs.
REQ-019 resp_w, resp_h  out  3 each  piece bounding box.

Function
REQ-020 Request accepted on the edge where req_valid and req_ready are both high (cycle A); all req_* inputs latched then.
REQ-021 FSM states: IDLE, CALC, READ, WAIT, DONE.
REQ-022 Transitions: IDLE->CALC on accept; CALC->DONE if EMPTY or OOB, else CALC->READ; READ lasts exactly 4 cycles, then WAIT (1 cycle), then DONE; DONE->IDLE when resp_ready is high.
REQ-023 CALC: cell indices, width and height come from the standard tetromino geometry table; shapes per rotation are fixed in the shared header.
REQ-024 OOB: resp_oob=1 if x+w>BOARD_W or y+h>BOARD_H, evaluated at X_W+1 / Y_W+1 bits with no wrap. If OOB, no rd_en is issued and resp_cells is all-ones.
REQ-025 READ cycle k (k=0..3): rd_en=1 and rd_addr=cell k+1. rd_en=0 in all other states.
REQ-026 resp_hit is the OR of the four rd_data samples. There is no early exit on a hit, so latency is deterministic.
REQ-027 resp_fit = !oob && !hit. EMPTY gives fit=1, oob=0, hit=0, cells all-ones, w=h=0.
REQ-028 Latency: resp_valid rises in cycle A+7 for in-bounds pieces and in cycle A+2 for EMPTY or OOB.
REQ-029 While in DONE, all resp_* outputs stay stable and req_ready stays 0 regardless of resp_ready duration.
REQ-030 A request cannot be accepted in the same cycle a response is accepted; the earliest next accept is the cycle after DONE->IDLE.
REQ-031 req_rot values are taken mod the piece's symmetry: I, S and Z treat 2 as 0 and 3 as 1; O ignores rotation.

Reset
REQ-032 On rst, the FSM SHALL go to IDLE and all outputs SHALL be 0 except req_ready=1, including when rst arrives mid-READ or in DONE.
REQ-033 rd_en SHALL be 0 in the cycle after rst is sampled, and no partial result SHALL be emitted.

Structure
REQ-034 The shared header global.vh SHALL hold the piece codes, the sentinel ERR_BLK_POS (all-ones), the rotation width and the BITS_* widths.
REQ-035 Geometry SHALL be a combinational sub-module, block_cells, parametrised by BOARD_W, that produces four indices plus w/h.
REQ-036 block_fit_check SHALL contain the FSM, the bounds comparators, the read sequencer and the hit accumulator.

Verification (BOARD_W=10, BOARD_H=20)
REQ-037 O, x=0, y=0, empty board -> cells {0,1,10,11}, fit=1, resp_valid at A+7.
REQ-038 I, rot=1, x=7, y=0 -> oob=1, fit=0, no rd_en pulses, resp_valid at A+2.
REQ-039 T, rot=0, x=4, y=18, cell 195 occupied -> rd_addr sequence 185, 194, 195, 196; hit=1, fit=0.
REQ-040 resp_ready held low for 3 cycles in DONE -> outputs stable, req_ready=0; accept on the 4th cycle -> IDLE next cycle.
REQ-041 rst pulsed during the 2nd READ cycle -> rd_en=0 the following cycle, req_ready=1, resp_valid never rises.
REQ-042 EMPTY request -> fit=1, cells all-ones, w=h=0, resp_valid at A+2.

Source files
------------

// File: rtl/block_fit_check_pkg.sv
// Shared definitions for the tetromino fit checker: piece codes, FSM states,
// field widths, the invalid-position sentinel and the per-rotation shape table.
package block_fit_check_pkg;

  localparam int BITS_BLK = 3;
  localparam int BITS_ROT = 2;
  localparam int BITS_OFF = 2;
  localparam int BITS_DIM = 3;

  localparam logic [31:0] ERR_BLK_POS = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    BLK_EMPTY = 3'd0,
    BLK_I     = 3'd1,
    BLK_O     = 3'd2,
    BLK_T     = 3'd3,
    BLK_S     = 3'd4,
    BLK_Z     = 3'd5,
    BLK_J     = 3'd6,
    BLK_L     = 3'd7
  } blk_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_READ = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0][BITS_OFF-1:0] dx;
    logic [3:0][BITS_OFF-1:0] dy;
    logic [BITS_DIM-1:0]      w;
    logic [BITS_DIM-1:0]      h;
  } shape_t;

  // Offset lists are written cell 1 first; cells are in row-major reading order.
  function automatic shape_t mk_shape(input logic [7:0] dxs, input logic [7:0] dys,
                                      input logic [2:0] w, input logic [2:0] h);
    shape_t s;
    s.dx[0] = dxs[7:6];
    s.dx[1] = dxs[5:4];
    s.dx[2] = dxs[3:2];
    s.dx[3] = dxs[1:0];
    s.dy[0] = dys[7:6];
    s.dy[1] = dys[5:4];
    s.dy[2] = dys[3:2];
    s.dy[3] = dys[1:0];
    s.w = w;
    s.h = h;
    return s;
  endfunction

  function automatic shape_t get_shape(input logic [2:0] blk, input logic [1:0] rot);
    logic [1:0] r;
    shape_t     s;
    case (blk)
      BLK_I, BLK_S, BLK_Z: r = {1'b0, rot[0]};
      BLK_O:               r = 2'd0;
      default:             r = rot;
    endcase
    s = '0;
    case ({blk, r})
      {BLK_I, 2'd0}: s = mk_shape({2'd0, 2'd0, 2'd0, 2'd0}, {2'd0, 2'd1, 2'd2, 2'd3}, 3'd1, 3'd4);
      {BLK_I, 2'd1}: s = mk_shape({2'd0, 2'd1, 2'd2, 2'd3}, {2'd0, 2'd0, 2'd0, 2'd0}, 3'd4, 3'd1);
      {BLK_O, 2'd0}: s = mk_shape({2'd0, 2'd1, 2'd0, 2'd1}, {2'd0, 2'd0, 2'd1, 2'd1}, 3'd2, 3'd2);
      {BLK_T, 2'd0}: s = mk_shape({2'd1, 2'd0, 2'd1, 2'd2}, {2'd0, 2'd1, 2'd1, 2'd1}, 3'd3, 3'd2);
      {BLK_T, 2'd1}: s = mk_shape({2'd0, 2'd0, 2'd1, 2'd0}, {2'd0, 2'd1, 2'd1, 2'd2}, 3'd2, 3'd3);
      {BLK_T, 2'd2}: s = mk_shape({2'd0, 2'd1, 2'd2, 2'd1}, {2'd0, 2'd0, 2'd0, 2'd1}, 3'd3, 3'd2);
      {BLK_T, 2'd3}: s = mk_shape({2'd1, 2'd0, 2'd1, 2'd1}, {2'd0, 2'd1, 2'd1, 2'd2}, 3'd2, 3'd3);
      {BLK_S, 2'd0}: s = mk_shape({2'd1, 2'd2, 2'd0, 2'd1}, {2'd0, 2'd0, 2'd1, 2'd1}, 3'd3, 3'd2);
      {BLK_S, 2'd1}: s = mk_shape({2'd0, 2'd0, 2'd1, 2'd1}, {2'd0, 2'd1, 2'd1, 2'd2}, 3'd2, 3'd3);
      {BLK_Z, 2'd0}: s = mk_shape({2'd0, 2'd1, 2'd1, 2'd2}, {2'd0, 2'd0, 2'd1, 2'd1}, 3'd3, 3'd2);
      {BLK_Z, 2'd1}: s = mk_shape({2'd1, 2'd0, 2'd1, 2'd0}, {2'd0, 2'd1, 2'd1, 2'd2}, 3'd2, 3'd3);
      {BLK_J, 2'd0}: s = mk_shape({2'd0, 2'd0, 2'd1, 2'd2}, {2'd0, 2'd1, 2'd1, 2'd1}, 3'd3, 3'd2);
      {BLK_J, 2'd1}: s = mk_shape({2'd0, 2'd1, 2'd0, 2'd0}, {2'd0, 2'd0, 2'd1, 2'd2}, 3'd2, 3'd3);
      {BLK_J, 2'd2}: s = mk_shape({2'd0, 2'd1, 2'd2, 2'd2}, {2'd0, 2'd0, 2'd0, 2'd1}, 3'd3, 3'd2);
      {BLK_J, 2'd3}: s = mk_shape({2'd1, 2'd1, 2'd0, 2'd1}, {2'd0, 2'd1, 2'd2, 2'd2}, 3'd2, 3'd3);
      {BLK_L, 2'd0}: s = mk_shape({2'd2, 2'd0, 2'd1, 2'd2}, {2'd0, 2'd1, 2'd1, 2'd1}, 3'd3, 3'd2);
      {BLK_L, 2'd1}: s = mk_shape({2'd0, 2'd0, 2'd0, 2'd1}, {2'd0, 2'd1, 2'd2, 2'd2}, 3'd2, 3'd3);
      {BLK_L, 2'd2}: s = mk_shape({2'd0, 2'd1, 2'd2, 2'd0}, {2'd0, 2'd0, 2'd0, 2'd1}, 3'd3, 3'd2);
      {BLK_L, 2'd3}: s = mk_shape({2'd0, 2'd1, 2'd1, 2'd1}, {2'd0, 2'd0, 2'd1, 2'd2}, 3'd2, 3'd3);
      default:       s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/block_cells.sv
// Combinational piece geometry: four board cell indices and the bounding box
// for a piece anchored at (x, y) with the given rotation.
module block_cells
  import block_fit_check_pkg::*;
#(
  parameter  int BOARD_W = 10,
  parameter  int BOARD_H = 20,
  localparam int X_W     = $clog2(BOARD_W),
  localparam int Y_W     = $clog2(BOARD_H),
  localparam int A_W     = $clog2(BOARD_W * BOARD_H)
) (
  input  logic [BITS_BLK-1:0] blk,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [BITS_ROT-1:0] rot,
  output logic [4*A_W-1:0]    cells,
  output logic [BITS_DIM-1:0] w,
  output logic [BITS_DIM-1:0] h
);

  shape_t shape;

  // Cell i lives at (y + dy_i) * BOARD_W + (x + dx_i); out-of-range results are discarded upstream.
  always_comb begin
    shape = get_shape(blk, rot);
    w     = shape.w;
    h     = shape.h;
    cells = '0;
    for (int i = 0; i < 4; i++) begin
      cells[i*A_W +: A_W] = A_W'((32'(y) + 32'(shape.dy[i])) * 32'(BOARD_W)
                                 + 32'(x) + 32'(shape.dx[i]));
    end
  end

endmodule

// File: rtl/block_fit_check.sv
// Checks whether a tetromino fits on the board: bounds test, four sequential
// occupancy reads, hit accumulation and a held response handshake.
module block_fit_check
  import block_fit_check_pkg::*;
#(
  parameter  int BOARD_W = 10,
  parameter  int BOARD_H = 20,
  localparam int X_W     = $clog2(BOARD_W),
  localparam int Y_W     = $clog2(BOARD_H),
  localparam int A_W     = $clog2(BOARD_W * BOARD_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [BITS_BLK-1:0] req_block,
  input  logic [X_W-1:0]      req_x,
  input  logic [Y_W-1:0]      req_y,
  input  logic [BITS_ROT-1:0] req_rot,
  output logic                rd_en,
  output logic [A_W-1:0]      rd_addr,
  input  logic                rd_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_fit,
  output logic                resp_oob,
  output logic                resp_hit,
  output logic [4*A_W-1:0]    resp_cells,
  output logic [BITS_DIM-1:0] resp_w,
  output logic [BITS_DIM-1:0] resp_h
);

  localparam logic [X_W:0]       W_LIM     = (X_W + 1)'(BOARD_W);
  localparam logic [Y_W:0]       H_LIM     = (Y_W + 1)'(BOARD_H);
  localparam logic [4*A_W-1:0]   CELLS_ERR = {4{ERR_BLK_POS[A_W-1:0]}};

  state_e              state;
  logic [BITS_BLK-1:0] blk_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [BITS_ROT-1:0] rot_q;
  logic [1:0]          rd_cnt;
  logic                hit_acc;

  logic [4*A_W-1:0]    geo_cells;
  logic [BITS_DIM-1:0] geo_w;
  logic [BITS_DIM-1:0] geo_h;
  logic                is_empty;
  logic                oob;
  logic                hit_now;
  logic [A_W-1:0]      next_addr;

  block_cells #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H)
  ) u_cells (
    .blk   (blk_q),
    .x     (x_q),
    .y     (y_q),
    .rot   (rot_q),
    .cells (geo_cells),
    .w     (geo_w),
    .h     (geo_h)
  );

  // Sums are one bit wider than the anchor so a large anchor cannot wrap back in bounds.
  assign is_empty = (blk_q == BLK_EMPTY);
  assign oob      = (((X_W + 1)'(x_q) + (X_W + 1)'(geo_w)) > W_LIM) ||
                    (((Y_W + 1)'(y_q) + (Y_W + 1)'(geo_h)) > H_LIM);
  assign hit_now  = hit_acc | rd_data;

  // Address for the read following the one currently on rd_addr.
  always_comb begin
    next_addr = resp_cells[0 +: A_W];
    case (rd_cnt)
      2'd0:    next_addr = resp_cells[1*A_W +: A_W];
      2'd1:    next_addr = resp_cells[2*A_W +: A_W];
      2'd2:    next_addr = resp_cells[3*A_W +: A_W];
      default: next_addr = resp_cells[0 +: A_W];
    endcase
  end

  // Control FSM with the read sequencer and hit accumulator; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      blk_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rot_q      <= '0;
      rd_cnt     <= 2'd0;
      hit_acc    <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      resp_valid <= 1'b0;
      resp_fit   <= 1'b0;
      resp_oob   <= 1'b0;
      resp_hit   <= 1'b0;
      resp_cells <= '0;
      resp_w     <= '0;
      resp_h     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            blk_q     <= req_block;
            x_q       <= req_x;
            y_q       <= req_y;
            rot_q     <= req_rot;
            req_ready <= 1'b0;
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          resp_w  <= geo_w;
          resp_h  <= geo_h;
          rd_cnt  <= 2'd0;
          hit_acc <= 1'b0;
          if (is_empty || oob) begin
            resp_cells <= CELLS_ERR;
            resp_oob   <= !is_empty;
            resp_fit   <= is_empty;
            resp_hit   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= ST_DONE;
          end else begin
            resp_cells <= geo_cells;
            rd_en      <= 1'b1;
            rd_addr    <= geo_cells[0 +: A_W];
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          // rd_data answers the previous strobe, so the first READ cycle has nothing to sample.
          if (rd_cnt != 2'd0) begin
            hit_acc <= hit_now;
          end
          if (rd_cnt == 2'd3) begin
            rd_en <= 1'b0;
            state <= ST_WAIT;
          end else begin
            rd_addr <= next_addr;
          end
          rd_cnt <= rd_cnt + 2'd1;
        end
        ST_WAIT: begin
          resp_hit   <= hit_now;
          resp_fit   <= !hit_now;
          resp_oob   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          rd_en      <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_fit_check.sv
// Randomised scoreboard bench for block_fit_check on a 10x20 board with a
// geometric reference model (rotate base shapes, sort, bounds, board lookup).
module tb_block_fit_check;

  localparam int BW  = 10;
  localparam int BH  = 20;
  localparam int A_W = 8;
  localparam int ERR = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_block;
  logic [3:0]  req_x;
  logic [4:0]  req_y;
  logic [1:0]  req_rot;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic        rd_data = 1'b0;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_fit;
  logic        resp_oob;
  logic        resp_hit;
  logic [31:0] resp_cells;
  logic [2:0]  resp_w;
  logic [2:0]  resp_h;

  block_fit_check #(.BOARD_W(BW), .BOARD_H(BH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_block(req_block),
    .req_x(req_x), .req_y(req_y), .req_rot(req_rot),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_fit(resp_fit), .resp_oob(resp_oob), .resp_hit(resp_hit),
    .resp_cells(resp_cells), .resp_w(resp_w), .resp_h(resp_h)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fit, oob, hit, w, h, lat, n, acc;
    int cells[4];
  } exp_t;

  exp_t exp_q[$];
  int   rd_q[$];
  logic board [BW*BH];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   force_hold = -1;
  int   hold_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Board memory: occupancy returned one cycle after the strobe.
  always @(posedge clk) rd_data <= (rd_en && int'(rd_addr) < BW*BH) ? board[rd_addr] : 1'b0;

  function automatic void chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: rotate the rot-0 shape clockwise, normalise to reading order, then test bounds and board.
  function automatic void model(input int blk, input int rot, input int x, input int y, output exp_t e);
    int px[4];
    int py[4];
    int r, hh, ww, t, hit;
    e.fit = 1; e.oob = 0; e.hit = 0; e.w = 0; e.h = 0; e.lat = 2; e.n = 0; e.acc = 0;
    for (int i = 0; i < 4; i++) e.cells[i] = ERR;
    if (blk == 0) return;
    case (blk)
      1: begin px = '{0, 0, 0, 0}; py = '{0, 1, 2, 3}; end
      2: begin px = '{0, 1, 0, 1}; py = '{0, 0, 1, 1}; end
      3: begin px = '{1, 0, 1, 2}; py = '{0, 1, 1, 1}; end
      4: begin px = '{1, 2, 0, 1}; py = '{0, 0, 1, 1}; end
      5: begin px = '{0, 1, 1, 2}; py = '{0, 0, 1, 1}; end
      6: begin px = '{0, 0, 1, 2}; py = '{0, 1, 1, 1}; end
      default: begin px = '{2, 0, 1, 2}; py = '{0, 1, 1, 1}; end
    endcase
    r = (blk == 2) ? 0 : ((blk == 1 || blk == 4 || blk == 5) ? rot % 2 : rot);
    for (int k = 0; k < r; k++) begin
      hh = 0;
      for (int i = 0; i < 4; i++) if (py[i] + 1 > hh) hh = py[i] + 1;
      for (int i = 0; i < 4; i++) begin t = px[i]; px[i] = hh - 1 - py[i]; py[i] = t; end
    end
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 3; b++)
        if (py[b]*4 + px[b] > py[b+1]*4 + px[b+1]) begin
          t = px[b]; px[b] = px[b+1]; px[b+1] = t;
          t = py[b]; py[b] = py[b+1]; py[b+1] = t;
        end
    ww = 0; hh = 0;
    for (int i = 0; i < 4; i++) begin
      if (px[i] + 1 > ww) ww = px[i] + 1;
      if (py[i] + 1 > hh) hh = py[i] + 1;
    end
    e.w = ww; e.h = hh;
    if (x + ww > BW || y + hh > BH) begin
      e.oob = 1; e.fit = 0;
      return;
    end
    hit = 0;
    for (int i = 0; i < 4; i++) begin
      e.cells[i] = (y + py[i]) * BW + x + px[i];
      if (board[e.cells[i]]) hit = 1;
    end
    e.hit = hit; e.fit = !hit; e.lat = 7; e.n = 4;
  endfunction

  // Consumer: keeps resp_ready low for hold_left cycles of a response, then accepts.
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (resp_valid && !resp_ready) begin
        if (hold_left > 0) hold_left--;
        else resp_ready = 1'b1;
      end else begin
        resp_ready = 1'b0;
        hold_left = (force_hold >= 0) ? force_hold : $urandom_range(0, 3);
      end
    end
  end

  // Monitor: pops the scoreboard on each new response and checks the hold/release handshake.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [40:0] snap = '0;
  wire  [40:0] snap_now = {resp_fit, resp_oob, resp_hit, resp_cells, resp_w, resp_h};
  exp_t        me;
  longint      ec;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      rd_q.delete();
    end else begin
      if (rd_en) rd_q.push_back(int'(rd_addr));
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", resp_valid, 1);
        chk("hold_stable", snap_now, snap);
        chk("hold_req_ready", req_ready, 0);
      end
      if (prev_valid && prev_ready) begin
        chk("release_valid", resp_valid, 0);
        chk("release_req_ready", req_ready, 1);
      end
      if (resp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          me = exp_q.pop_front();
          ec = 0;
          for (int i = 0; i < 4; i++) ec = ec | (longint'(me.cells[i]) << (i * A_W));
          chk("latency", cyc - me.acc, me.lat);
          chk("fit", resp_fit, me.fit);
          chk("oob", resp_oob, me.oob);
          chk("hit", resp_hit, me.hit);
          chk("cells", resp_cells, ec);
          chk("w", resp_w, me.w);
          chk("h", resp_h, me.h);
          chk("rd_count", rd_q.size(), me.n);
          if (rd_q.size() == me.n)
            for (int i = 0; i < me.n; i++) chk("rd_addr", rd_q[i], me.cells[i]);
          rd_q.delete();
        end
      end
      prev_valid = resp_valid;
      prev_ready = resp_ready;
      snap       = snap_now;
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (!(req_ready && exp_q.size() == 0) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("idle_within_budget", (g < 200) ? 1 : 0, 1);
  endtask

  task automatic issue(input int blk, input int rot, input int x, input int y);
    exp_t e;
    int   g = 0;
    while (!req_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 0, 1);
    end else begin
      model(blk, rot, x, y, e);
      e.acc = cyc;
      exp_q.push_back(e);
      req_block = 3'(blk); req_rot = 2'(rot); req_x = 4'(x); req_y = 5'(y);
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_block = 3'($urandom); req_x = 4'($urandom); req_y = 5'($urandom);
    end
  endtask

  task automatic reset_mid_read();
    int seen = 0;
    wait_idle();
    req_block = 3'd3; req_rot = 2'd0; req_x = 4'd2; req_y = 5'd5;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_rd_en_k0", rd_en, 1);
    @(posedge clk); #1;
    chk("rst_pre_rd_en_k1", rd_en, 1);
    chk("rst_pre_rd_addr_k1", rd_addr, 6*BW + 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    for (int i = 0; i < 12; i++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    chk("rst_no_resp", seen, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_block = 3'd0; req_x = 4'd0; req_y = 5'd0; req_rot = 2'd0;
    for (int i = 0; i < BW*BH; i++) board[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_resp_cells", resp_cells, 0);
    chk("reset_flags", {resp_fit, resp_oob, resp_hit, resp_w, resp_h}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(2, 0, 0, 0);                 // O at origin on an empty board
    issue(2, 3, 8, 18);                // O ignores rotation, touches both edges
    issue(1, 1, 7, 0);                 // horizontal I sticks out on the right
    issue(1, 3, 6, 16);                // rot 3 behaves as rot 1, exactly fits
    issue(1, 0, 0, 16);                // vertical I fits at bottom
    issue(1, 2, 0, 17);                // vertical I one row too low
    issue(0, 2, 13, 30);               // EMPTY ignores its anchor
    issue(7, 1, 15, 31);               // anchor far beyond the board
    wait_idle();
    board[195] = 1'b1;
    issue(3, 0, 4, 18);                // T hits cell 195
    wait_idle();
    force_hold = 3;
    issue(6, 2, 3, 3);
    wait_idle();
    force_hold = -1;

    reset_mid_read();

    for (int n = 0; n < 64; n++) begin
      if (n % 8 == 0) begin
        wait_idle();
        for (int i = 0; i < BW*BH; i++) board[i] = ($urandom_range(0, 3) == 0);
      end
      issue($urandom_range(0, 7), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 19));
    end
    wait_idle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
